// File: rtl/riscv_dcache_dm_pkg.sv
// riscv_dcache_dm_pkg: store size codes, cache FSM states and the
// store byte-lane / data-replication helpers shared by the data cache.
package riscv_dcache_dm_pkg;

   localparam int CACHE_D_WRITE_LEN = 2;
   localparam logic [CACHE_D_WRITE_LEN-1:0] CACHE_D_WRITE_SB = 2'd0;
   localparam logic [CACHE_D_WRITE_LEN-1:0] CACHE_D_WRITE_SH = 2'd1;
   localparam logic [CACHE_D_WRITE_LEN-1:0] CACHE_D_WRITE_SW = 2'd2;

   localparam int DCACHE_ST_LEN = 2;

   typedef enum logic [DCACHE_ST_LEN-1:0] {
      DCACHE_ST_IDLE   = 2'd0,
      DCACHE_ST_LOOKUP = 2'd1,
      DCACHE_ST_FILL   = 2'd2,
      DCACHE_ST_WRITE  = 2'd3
   } dcache_st_e;

   // The unused size encoding behaves as a word store.
   function automatic logic st_misaligned(
      input logic [CACHE_D_WRITE_LEN-1:0] size,
      input logic [1:0]                   off
   );
      logic bad;
      case (size)
         CACHE_D_WRITE_SB: bad = 1'b0;
         CACHE_D_WRITE_SH: bad = off[0];
         default:          bad = (off != 2'b00);
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] st_lanes(
      input logic [CACHE_D_WRITE_LEN-1:0] size,
      input logic [1:0]                   off
   );
      logic [3:0] be;
      case (size)
         CACHE_D_WRITE_SB: be = 4'b0001 << off;
         CACHE_D_WRITE_SH: be = 4'b0011 << off;
         default:          be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] st_data(
      input logic [CACHE_D_WRITE_LEN-1:0] size,
      input logic [31:0]                  wdata
   );
      logic [31:0] d;
      case (size)
         CACHE_D_WRITE_SB: d = {4{wdata[7:0]}};
         CACHE_D_WRITE_SH: d = {2{wdata[15:0]}};
         default:          d = wdata;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/riscv_dcache_dm_data_ram.sv
// riscv_dcache_data_ram: synchronous-read data store with byte write
// enables; a same-cycle write to the read address is forwarded.
module riscv_dcache_data_ram #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   localparam int DEPTH = 1 << AW;

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;
   logic        fwd;

   assign fwd = (waddr_i == raddr_i);

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we_i[b])
            mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         if (re_i)
            rdata_q[8*b +: 8] <= (we_i[b] && fwd) ?
                                 wdata_i[8*b +: 8] :
                                 mem_q[raddr_i][8*b +: 8];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/riscv_dcache_dm.sv
// riscv_dcache_dm: direct-mapped, write-through, no-write-allocate data
// cache. Define RISCV_DCACHE_STATS_EN to build the hit/miss counters.
module riscv_dcache_dm
   import riscv_dcache_dm_pkg::*;
#(
   parameter int LINES          = 64,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cpu_req,
   output logic                         cpu_ready,
   input  logic                         cpu_we,
   input  logic [CACHE_D_WRITE_LEN-1:0] cpu_size,
   input  logic [31:0]                  cpu_addr,
   input  logic [31:0]                  cpu_wdata,
   input  logic                         cpu_inv,
   output logic                         cpu_resp,
   output logic [31:0]                  cpu_rdata,
   output logic                         cpu_err,
   output logic                         mem_req,
   output logic                         mem_we,
   output logic [31:0]                  mem_addr,
   output logic [3:0]                   mem_be,
   output logic [31:0]                  mem_wdata,
   input  logic                         mem_ack,
   input  logic [31:0]                  mem_rdata,
   output logic [31:0]                  hit_cnt,
   output logic [31:0]                  miss_cnt
);

   localparam int WB = $clog2(WORDS_PER_LINE);
   localparam int IB = $clog2(LINES);
   localparam int AW = WB + IB;
   localparam int TW = 30 - AW;
   localparam int KW = (WB == 0) ? 1 : WB;

   dcache_st_e state_q, state_d;

   logic [31:0]                  addr_q;
   logic                         we_q;
   logic [CACHE_D_WRITE_LEN-1:0] size_q;
   logic [31:0]                  wdata_q;
   logic [KW-1:0]                k_q, k_d;
   logic                         hit_q, hit_d;
   logic                         refill_q, refill_d;
   logic [LINES-1:0]             valid_q;
   logic [TW-1:0]                tag_q [LINES];

   logic [AW-1:0] ridx;
   logic [IB-1:0] line;
   logic [TW-1:0] tag;
   logic          hit;
   logic          fill_last;
   logic [31:0]   line_base;
   logic [3:0]    lanes;
   logic [31:0]   sdata;

   logic          accept, inv_all, tag_we;
   logic          cnt_hit, cnt_miss;
   logic          ram_re;
   logic [AW-1:0] ram_raddr, ram_waddr;
   logic [3:0]    ram_be;
   logic [31:0]   ram_wdata, ram_rdata;

   assign ridx      = addr_q[2 +: AW];
   assign line      = addr_q[2 + WB +: IB];
   assign tag       = addr_q[31 -: TW];
   assign hit       = valid_q[line] && (tag_q[line] == tag);
   assign fill_last = (k_q == KW'(WORDS_PER_LINE - 1));
   assign line_base = addr_q & ~32'(WORDS_PER_LINE * 4 - 1);
   assign lanes     = st_lanes(size_q, addr_q[1:0]);
   assign sdata     = st_data(size_q, wdata_q);

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      hit_d     = hit_q;
      refill_d  = refill_q;
      cpu_ready = 1'b0;
      cpu_resp  = 1'b0;
      cpu_err   = 1'b0;
      cpu_rdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      accept    = 1'b0;
      inv_all   = 1'b0;
      tag_we    = 1'b0;
      cnt_hit   = 1'b0;
      cnt_miss  = 1'b0;
      ram_re    = 1'b0;
      ram_raddr = ridx;
      ram_be    = '0;
      ram_waddr = ridx;
      ram_wdata = '0;
      unique case (state_q)
         DCACHE_ST_IDLE: begin
            cpu_ready = !cpu_inv;
            if (cpu_inv) begin
               inv_all = 1'b1;
            end else if (cpu_req) begin
               accept    = 1'b1;
               ram_re    = 1'b1;
               ram_raddr = cpu_addr[2 +: AW];
               refill_d  = 1'b0;
               state_d   = DCACHE_ST_LOOKUP;
            end
         end
         DCACHE_ST_LOOKUP: begin
            if (!we_q) begin
               if (hit) begin
                  cpu_resp  = 1'b1;
                  cpu_rdata = ram_rdata;
                  cnt_hit   = !refill_q;
                  state_d   = DCACHE_ST_IDLE;
               end else begin
                  k_d      = '0;
                  cnt_miss = 1'b1;
                  state_d  = DCACHE_ST_FILL;
               end
            end else if (st_misaligned(size_q, addr_q[1:0])) begin
               cpu_resp = 1'b1;
               cpu_err  = 1'b1;
               state_d  = DCACHE_ST_IDLE;
            end else begin
               hit_d    = hit;
               cnt_hit  = hit;
               cnt_miss = !hit;
               state_d  = DCACHE_ST_WRITE;
            end
         end
         DCACHE_ST_FILL: begin
            mem_req  = 1'b1;
            mem_be   = 4'b1111;
            mem_addr = line_base | (32'(k_q) << 2);
            if (mem_ack) begin
               ram_be    = 4'b1111;
               ram_waddr = (ridx & ~AW'(WORDS_PER_LINE - 1)) | AW'(k_q);
               ram_wdata = mem_rdata;
               k_d       = k_q + 1'b1;
               if (fill_last) begin
                  // Re-read the requested word; the RAM forwards it
                  // if it is the word being written this cycle.
                  k_d      = '0;
                  tag_we   = 1'b1;
                  ram_re   = 1'b1;
                  refill_d = 1'b1;
                  state_d  = DCACHE_ST_LOOKUP;
               end
            end
         end
         DCACHE_ST_WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {addr_q[31:2], 2'b00};
            mem_be    = lanes;
            mem_wdata = sdata;
            if (mem_ack) begin
               if (hit_q) begin
                  ram_be    = lanes;
                  ram_wdata = sdata;
               end
               cpu_resp = 1'b1;
               state_d  = DCACHE_ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= DCACHE_ST_IDLE;
         addr_q   <= '0;
         we_q     <= 1'b0;
         size_q   <= '0;
         wdata_q  <= '0;
         k_q      <= '0;
         hit_q    <= 1'b0;
         refill_q <= 1'b0;
         valid_q  <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         hit_q    <= hit_d;
         refill_q <= refill_d;
         if (accept) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            size_q  <= cpu_size;
            wdata_q <= cpu_wdata;
         end
         if (inv_all)
            valid_q <= '0;
         else if (tag_we)
            valid_q[line] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_we)
         tag_q[line] <= tag;
   end

   riscv_dcache_data_ram #(
      .AW (AW)
   ) u_data_ram (
      .clk     (clk),
      .re_i    (ram_re),
      .raddr_i (ram_raddr),
      .we_i    (ram_be),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

`ifdef RISCV_DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (cnt_hit && hit_cnt_q != '1)
            hit_cnt_q <= hit_cnt_q + 1'b1;
         if (cnt_miss && miss_cnt_q != '1)
            miss_cnt_q <= miss_cnt_q + 1'b1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = ^{cnt_hit, cnt_miss, refill_q};
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_dcache_dm.sv
// tb_riscv_dcache_dm: scoreboard bench with a behavioural cache/memory
// reference model and a randomly delayed word-wide memory responder.
module tb_riscv_dcache_dm;

   logic        clk;
   logic        rst;
   logic        cpu_req;
   logic        cpu_ready;
   logic        cpu_we;
   logic [1:0]  cpu_size;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_inv;
   logic        cpu_resp;
   logic [31:0] cpu_rdata;
   logic        cpu_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

`ifdef RISCV_DCACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   localparam logic [1:0] SB = 2'd0;
   localparam logic [1:0] SH = 2'd1;
   localparam logic [1:0] SW = 2'd2;

   riscv_dcache_dm dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_ready (cpu_ready),
      .cpu_we    (cpu_we),
      .cpu_size  (cpu_size),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_inv   (cpu_inv),
      .cpu_resp  (cpu_resp),
      .cpu_rdata (cpu_rdata),
      .cpu_err   (cpu_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      bit          err;
      bit          lat1;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } mtx_t;

   exp_t expq[$];
   mtx_t memq[$];

   logic [31:0] bmem [4096];
   logic [31:0] rmem [4096];
   bit          cv [64];
   logic [31:0] cb [64];
   int          m_hit, m_miss;
   int          n_vec, n_bad;
   int          ack_total;
   int          dly;

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 64; i++) cv[i] = 0;
      m_hit  = 0;
      m_miss = 0;
   endfunction

   task automatic chk_cnt(string nm);
      chk({nm, "_hit_cnt"}, hit_cnt, STATS ? 32'(m_hit) : 32'd0);
      chk({nm, "_miss_cnt"}, miss_cnt, STATS ? 32'(m_miss) : 32'd0);
   endtask

   // Memory responder: random 0..3 cycle ack delay, checks traffic.
   initial begin
      mtx_t t;
      int   w;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      dly       = -1;
      forever begin
         @(posedge clk);
         #1;
         if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (!rst || !mem_req) begin
            dly = -1;
         end else begin
            if (dly < 0) dly = int'($urandom_range(0, 3));
            if (dly == 0) begin
               dly     = -1;
               mem_ack = 1'b1;
               ack_total++;
               if (memq.size() == 0) begin
                  n_vec++;
                  n_bad++;
                  $display("FAIL mem_unexpected: addr %h we %0d",
                           mem_addr, mem_we);
               end else begin
                  t = memq.pop_front();
                  chk("mem_we", 32'(mem_we), 32'(t.we));
                  chk("mem_addr", mem_addr, t.addr);
                  if (t.we) begin
                     chk("mem_be", 32'(mem_be), 32'(t.be));
                     chk("mem_wdata", mem_wdata, t.wdata);
                  end
               end
               w = int'(mem_addr[13:2]);
               if (mem_we) begin
                  for (int b = 0; b < 4; b++)
                     if (mem_be[b])
                        bmem[w][8*b +: 8] = mem_wdata[8*b +: 8];
               end else begin
                  mem_rdata = bmem[w];
               end
            end else begin
               dly--;
            end
         end
      end
   end

   // Response monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && cpu_resp) begin
            if (expq.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL resp_unexpected: addr %h", cpu_addr);
            end else begin
               e = expq.pop_front();
               chk("cpu_err", 32'(cpu_err), 32'(e.err));
               if (!e.we) chk("cpu_rdata", cpu_rdata, e.rdata);
               chk("mem_pending", 32'(memq.size()), 32'd0);
            end
         end
      end
   end

   function automatic bit model_hit(logic [31:0] addr);
      int idx;
      idx = int'((addr >> 4) & 32'd63);
      return cv[idx] && (cb[idx] == (addr & ~32'hF));
   endfunction

   function automatic void model_fill(logic [31:0] addr);
      mtx_t t;
      logic [31:0] base;
      base = addr & ~32'hF;
      for (int k = 0; k < 4; k++) begin
         t.we    = 0;
         t.addr  = base + 32'(4 * k);
         t.be    = 4'h0;
         t.wdata = '0;
         memq.push_back(t);
      end
      cv[int'((addr >> 4) & 32'd63)] = 1;
      cb[int'((addr >> 4) & 32'd63)] = base;
   endfunction

   task automatic issue(input bit we, input logic [1:0] size,
                        input logic [31:0] addr,
                        input logic [31:0] wdata);
      exp_t        e;
      mtx_t        t;
      bit          hit;
      logic [1:0]  off;
      logic [3:0]  be;
      logic [31:0] d;
      int          n;
      int          w;
      hit     = model_hit(addr);
      off     = addr[1:0];
      w       = int'(addr[13:2]);
      e.we    = we;
      e.err   = 0;
      e.lat1  = 0;
      e.rdata = '0;
      if (!we) begin
         if (hit) begin
            m_hit++;
            e.lat1 = 1;
         end else begin
            m_miss++;
            model_fill(addr);
         end
         e.rdata = rmem[w];
      end else if ((size == SW && off != 0) ||
                   (size == SH && off % 2 == 1)) begin
         e.err  = 1;
         e.lat1 = 1;
      end else begin
         case (size)
            SB: begin
               be = 4'(1 << off);
               d  = 32'(wdata[7:0]) * 32'h0101_0101;
            end
            SH: begin
               be = 4'(3 << off);
               d  = 32'(wdata[15:0]) * 32'h0001_0001;
            end
            default: begin
               be = 4'hF;
               d  = wdata;
            end
         endcase
         t.we    = 1;
         t.addr  = addr & ~32'h3;
         t.be    = be;
         t.wdata = d;
         memq.push_back(t);
         for (int b = 0; b < 4; b++)
            if (be[b]) rmem[w][8*b +: 8] = d[8*b +: 8];
         if (hit) m_hit++;
         else m_miss++;
      end
      expq.push_back(e);
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_size  = size;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      n = 0;
      while (!cpu_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!cpu_ready) begin
         chk("accept_timeout", 32'(cpu_ready), 32'd1);
         cpu_req = 1'b0;
         return;
      end
      @(posedge clk);
      #1 cpu_req = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cpu_resp && n < 200);
      if (!cpu_resp)
         chk("resp_timeout", 32'(cpu_resp), 32'd1);
      else if (e.lat1)
         chk("resp_latency", 32'(n), 32'd1);
   endtask

   task automatic do_inv();
      @(negedge clk);
      cpu_inv = 1'b1;
      @(posedge clk);
      #1 cpu_inv = 1'b0;
      for (int i = 0; i < 64; i++) cv[i] = 0;
   endtask

   initial begin
      int          n;
      int          start;
      logic [31:0] a;
      logic [1:0]  sz;
      for (int i = 0; i < 4096; i++) begin
         bmem[i] = $urandom;
         rmem[i] = bmem[i];
      end
      model_reset();
      n_vec     = 0;
      n_bad     = 0;
      ack_total = 0;
      rst       = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_size  = SW;
      cpu_addr  = '0;
      cpu_wdata = '0;
      cpu_inv   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cpu_resp", 32'(cpu_resp), 32'd0);
      chk("rst_cpu_err", 32'(cpu_err), 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk_cnt("rst");
      rst = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(cpu_ready), 32'd1);

      issue(0, SW, 32'h100, 0);
      chk_cnt("first_miss");
      issue(0, SW, 32'h104, 0);
      chk_cnt("first_hit");
      issue(1, SB, 32'h106, 32'h0000_00AB);
      issue(0, SW, 32'h104, 0);
      issue(1, SW, 32'h102, 32'h1234_5678);
      issue(1, SW, 32'h2000, 32'hCAFE_F00D);
      issue(0, SW, 32'h2000, 0);
      issue(1, SH, 32'h10A, 32'h0000_BEEF);
      issue(0, SW, 32'h108, 0);
      chk_cnt("directed");

      @(negedge clk);
      cpu_inv  = 1'b1;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h104;
      #1 chk("inv_ready", 32'(cpu_ready), 32'd0);
      @(posedge clk);
      #1;
      cpu_inv = 1'b0;
      cpu_req = 1'b0;
      @(negedge clk);
      chk("inv_not_accepted", 32'(cpu_ready), 32'd1);
      chk("inv_no_resp", 32'(cpu_resp), 32'd0);
      for (int i = 0; i < 64; i++) cv[i] = 0;
      issue(0, SW, 32'h104, 0);
      chk_cnt("after_inv");

      for (int i = 0; i < 300; i++) begin
         n = int'($urandom_range(0, 99));
         a = 32'($urandom_range(0, 32'hFFF));
         sz = 2'($urandom_range(0, 2));
         if (n < 5) do_inv();
         else if (n < 55) issue(0, SW, a, 0);
         else issue(1, sz, a, $urandom);
      end
      chk_cnt("random");

      a = 32'h340;
      model_fill(a);
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = a;
      start    = ack_total;
      @(posedge clk);
      #1 cpu_req = 1'b0;
      n = 0;
      while (ack_total < start + 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("mid_fill_acks", 32'(ack_total - start), 32'd2);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk("mid_fill_mem_req", 32'(mem_req), 32'd0);
      chk("mid_fill_resp", 32'(cpu_resp), 32'd0);
      memq.delete();
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      chk_cnt("post_reset");
      issue(0, SW, a, 0);
      chk_cnt("refill");
      repeat (3) @(negedge clk);
      chk("final_expq", 32'(expq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1);
   end

endmodule
